// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// the NOP instruction placed in the output register at reset, the default
// reset PC and a small helper that turns a PC into its 64-bit word address.
package ifu_pkg;

  localparam int XLEN = 64;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h8000_0000;
  localparam logic [31:0]     NOP_INST         = 32'h0000_0013;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    REQ   = ST_REQ,
    WAIT  = ST_WAIT,
    FLUSH = ST_FLUSH,
    HOLD  = ST_HOLD
  } ifu_state_e;

  // Instruction memory is 64 bits wide, so reads are always word aligned.
  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/ifu_pc_gen.sv
// Next-PC select for the fetch unit. Purely combinational: the PC register
// itself lives in ifu_fetch. A redirect always wins over sequential advance,
// and redirect targets are forced to a 4-byte boundary.
module ifu_pc_gen
  import ifu_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            advance,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc_next
);

  // Low two redirect bits are dropped by design; keep them visibly consumed.
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];

  // Select: redirect target, pc+4 (wraps modulo 2^64), or hold.
  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (advance) begin
      pc_next = pc + 64'd4;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit. Owns the PC, issues one 64-bit read at a time to
// instruction memory, picks the 32-bit half addressed by pc[2] and offers
// {inst, inst_pc} to decode. Redirects from execute may arrive in any state;
// a read already in flight is drained (FLUSH) rather than cancelled.
// Optional build macro: IFU_STALL_CNT_EN adds the stall_cnt output, which
// counts cycles spent in REQ, WAIT or FLUSH (saturating).
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] araddr,
  output logic            arvalid,
  input  logic            arready,
  input  logic [XLEN-1:0] rdata,
  input  logic            rvalid,
  output logic            rready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready
`ifdef IFU_STALL_CNT_EN
  ,
  output logic [XLEN-1:0] stall_cnt
`endif
);

  ifu_state_e      state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] araddr_reg;
  logic [XLEN-1:0] inst_pc_reg;
  logic [31:0]     inst_reg;
  logic            arvalid_reg;
  logic            rready_reg;
  logic            inst_valid_reg;
  logic            redirect_pend_reg;
  logic            advance;

  // Decode taking the held instruction moves the PC on; a simultaneous
  // redirect overrides it inside ifu_pc_gen.
  assign advance = (state_reg == HOLD) && inst_ready;

  ifu_pc_gen u_pc_gen (
    .pc             (pc_reg),
    .advance        (advance),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_next        (pc_next)
  );

  // Fetch FSM with registered handshake outputs. araddr is captured on entry
  // to REQ so a redirect during REQ cannot disturb the address being offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      pc_reg            <= RESET_PC;
      araddr_reg        <= word_addr(RESET_PC);
      arvalid_reg       <= 1'b0;
      rready_reg        <= 1'b0;
      inst_valid_reg    <= 1'b0;
      inst_reg          <= NOP_INST;
      inst_pc_reg       <= RESET_PC;
      redirect_pend_reg <= 1'b0;
    end else begin
      pc_reg <= pc_next;
      case (state_reg)
        IDLE: begin
          state_reg   <= REQ;
          arvalid_reg <= 1'b1;
          araddr_reg  <= word_addr(pc_next);
        end
        REQ: begin
          if (redirect_valid) begin
            redirect_pend_reg <= 1'b1;
          end
          if (arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            // The response to a stale address must be drained, not used.
            // redirect_pend stays set until FLUSH retires that response, so
            // it is never observed set in WAIT.
            if (redirect_valid || redirect_pend_reg) begin
              state_reg <= FLUSH;
            end else begin
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            if (rvalid) begin
              // Response consumed this cycle; nothing left to flush.
              rready_reg  <= 1'b0;
              state_reg   <= REQ;
              arvalid_reg <= 1'b1;
              araddr_reg  <= word_addr(pc_next);
            end else begin
              state_reg <= FLUSH;
            end
          end else if (rvalid) begin
            rready_reg     <= 1'b0;
            inst_reg       <= pc_reg[2] ? rdata[63:32] : rdata[31:0];
            inst_pc_reg    <= pc_reg;
            inst_valid_reg <= 1'b1;
            state_reg      <= HOLD;
          end
        end
        FLUSH: begin
          if (rvalid) begin
            rready_reg        <= 1'b0;
            redirect_pend_reg <= 1'b0;
            state_reg         <= REQ;
            arvalid_reg       <= 1'b1;
            araddr_reg        <= word_addr(pc_next);
          end
        end
        HOLD: begin
          if (redirect_valid || inst_ready) begin
            inst_valid_reg <= 1'b0;
            state_reg      <= REQ;
            arvalid_reg    <= 1'b1;
            araddr_reg     <= word_addr(pc_next);
          end
        end
        default: begin
          state_reg      <= IDLE;
          arvalid_reg    <= 1'b0;
          rready_reg     <= 1'b0;
          inst_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign araddr     = araddr_reg;
  assign arvalid    = arvalid_reg;
  assign rready     = rready_reg;
  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;
  assign inst_valid = inst_valid_reg;

`ifdef IFU_STALL_CNT_EN
  logic [XLEN-1:0] stall_cnt_reg;

  // Count cycles waiting on memory; holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (((state_reg == REQ) || (state_reg == WAIT) || (state_reg == FLUSH)) &&
                 (stall_cnt_reg != {XLEN{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 64'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
